l1c_mem_arbiter: RTL and testbench

Two-master arbiter that shares the single CPU-wrapper memory port between the L1 instruction cache and the L1 data cache. It accepts cache-side request bundles (req/addr/write/in/type) and grants one owner at a time. It holds the grant for a complete transaction: a 4-beat line refill on a read, or a single beat on a write. It routes the returned data and wait back to the owner and stalls the other cache.

---
 rtl/l1c_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_l1c_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l1c_mem_arbiter.sv
// Shares one CPU-wrapper memory port between the L1 I-cache and D-cache.
// Grants are held for a whole transaction and alternate round-robin on ties.
module l1c_mem_arbiter #(
   parameter int unsigned DATA_BITS = 32,
   parameter int unsigned TYPE_BITS = 3,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned CNT_BITS  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 I_req,
   input  logic                 I_write,
   input  logic [DATA_BITS-1:0] I_addr,
   input  logic [DATA_BITS-1:0] I_in,
   input  logic [TYPE_BITS-1:0] I_type,
   output logic [DATA_BITS-1:0] I_out,
   output logic                 I_wait,
   input  logic                 D_req,
   input  logic                 D_write,
   input  logic [DATA_BITS-1:0] D_addr,
   input  logic [DATA_BITS-1:0] D_in,
   input  logic [TYPE_BITS-1:0] D_type,
   output logic [DATA_BITS-1:0] D_out,
   output logic                 D_wait,
   output logic                 M_req,
   output logic                 M_write,
   output logic [DATA_BITS-1:0] M_addr,
   output logic [DATA_BITS-1:0] M_in,
   output logic [TYPE_BITS-1:0] M_type,
   input  logic [DATA_BITS-1:0] M_out,
   input  logic                 M_wait,
   output logic [1:0]           grant,
   output logic [CNT_BITS-1:0]  cnt_i_grants,
   output logic [CNT_BITS-1:0]  cnt_d_grants
);

   localparam int unsigned BEAT_BITS = $clog2(BURST_LEN) + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic                 last_d;
   logic                 wr_lat;
   logic [BEAT_BITS-1:0] beat;
   logic                 txn_done;

   // Final beat: one beat for a write, a full line refill otherwise.
   assign txn_done = (state != IDLE) && !M_wait &&
                     (wr_lat || (beat == BEAT_BITS'(BURST_LEN - 1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (I_req && D_req) state_nxt = last_d ? GRANT_I : GRANT_D;
            else if (D_req)     state_nxt = GRANT_D;
            else if (I_req)     state_nxt = GRANT_I;
         end
         GRANT_I, GRANT_D: begin
            if (txn_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Transaction bookkeeping; last_d=0 after reset so D wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_d       <= 1'b0;
         wr_lat       <= 1'b0;
         beat         <= '0;
         cnt_i_grants <= '0;
         cnt_d_grants <= '0;
      end else if (state == IDLE) begin
         beat <= '0;
         if (state_nxt == GRANT_I)      wr_lat <= I_write;
         else if (state_nxt == GRANT_D) wr_lat <= D_write;
      end else begin
         if (!M_wait) beat <= beat + BEAT_BITS'(1);
         if (txn_done) begin
            last_d <= (state == GRANT_D);
            if (state == GRANT_D) cnt_d_grants <= cnt_d_grants + CNT_BITS'(1);
            else                  cnt_i_grants <= cnt_i_grants + CNT_BITS'(1);
         end
      end
   end

   always_comb begin
      M_req   = 1'b0;
      M_write = 1'b0;
      M_addr  = '0;
      M_in    = '0;
      M_type  = '0;
      I_out   = '0;
      D_out   = '0;
      I_wait  = I_req;
      D_wait  = D_req;
      grant   = 2'b00;
      case (state)
         GRANT_I: begin
            M_req   = I_req;
            M_write = I_write;
            M_addr  = I_addr;
            M_in    = I_in;
            M_type  = I_type;
            I_out   = M_out;
            I_wait  = M_wait;
            grant   = 2'b01;
         end
         GRANT_D: begin
            M_req   = D_req;
            M_write = D_write;
            M_addr  = D_addr;
            M_in    = D_in;
            M_type  = D_type;
            D_out   = M_out;
            D_wait  = M_wait;
            grant   = 2'b10;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_l1c_mem_arbiter.sv
// Bench for l1c_mem_arbiter: transaction-level owner/remaining-beats model
// checked every cycle, plus directed literal expectations per scenario.
module tb_l1c_mem_arbiter;

   localparam int unsigned DW    = 32;
   localparam int unsigned TW    = 3;
   localparam int unsigned BL    = 4;
   localparam int unsigned CNT_W = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          I_req, I_write, D_req, D_write;
   logic [DW-1:0] I_addr, I_in, D_addr, D_in;
   logic [TW-1:0] I_type, D_type;
   logic [DW-1:0] I_out, D_out;
   logic          I_wait, D_wait;
   logic          M_req, M_write;
   logic [DW-1:0] M_addr, M_in, M_out;
   logic [TW-1:0] M_type;
   logic          M_wait;
   logic [1:0]    grant;
   logic [CNT_W-1:0] cnt_i_grants, cnt_d_grants;

   int checks = 0;
   int errors = 0;

   l1c_mem_arbiter #(.DATA_BITS(DW), .TYPE_BITS(TW), .BURST_LEN(BL), .CNT_BITS(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .I_req(I_req), .I_write(I_write), .I_addr(I_addr), .I_in(I_in), .I_type(I_type),
      .I_out(I_out), .I_wait(I_wait),
      .D_req(D_req), .D_write(D_write), .D_addr(D_addr), .D_in(D_in), .D_type(D_type),
      .D_out(D_out), .D_wait(D_wait),
      .M_req(M_req), .M_write(M_write), .M_addr(M_addr), .M_in(M_in), .M_type(M_type),
      .M_out(M_out), .M_wait(M_wait),
      .grant(grant), .cnt_i_grants(cnt_i_grants), .cnt_d_grants(cnt_d_grants)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: who owns the port and how many beats remain in the transaction.
   int owner = 0;       // 0 none, 1 I, 2 D
   int rem = 0;
   bit m_last_d = 1'b0;
   int m_cnt_i = 0;
   int m_cnt_d = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         owner    <= 0;
         rem      <= 0;
         m_last_d <= 1'b0;
         m_cnt_i  <= 0;
         m_cnt_d  <= 0;
      end else if (owner == 0) begin
         if (I_req && D_req) begin
            owner <= m_last_d ? 1 : 2;
            rem   <= m_last_d ? (I_write ? 1 : BL) : (D_write ? 1 : BL);
         end else if (D_req) begin
            owner <= 2;
            rem   <= D_write ? 1 : BL;
         end else if (I_req) begin
            owner <= 1;
            rem   <= I_write ? 1 : BL;
         end
      end else if (!M_wait) begin
         if (rem == 1) begin
            owner    <= 0;
            m_last_d <= (owner == 2);
            if (owner == 2) m_cnt_d <= (m_cnt_d + 1) % (1 << CNT_W);
            else            m_cnt_i <= (m_cnt_i + 1) % (1 << CNT_W);
         end else begin
            rem <= rem - 1;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      logic [1:0]    e_grant;
      logic          e_mreq, e_mwrite, e_iwait, e_dwait;
      logic [DW-1:0] e_maddr, e_min, e_iout, e_dout;
      logic [TW-1:0] e_mtype;
      e_grant = 2'b00; e_mreq = 1'b0; e_mwrite = 1'b0; e_maddr = '0; e_min = '0;
      e_mtype = '0; e_iout = '0; e_dout = '0; e_iwait = I_req; e_dwait = D_req;
      if (owner == 1) begin
         e_grant = 2'b01; e_mreq = I_req; e_mwrite = I_write; e_maddr = I_addr;
         e_min = I_in; e_mtype = I_type; e_iout = M_out; e_iwait = M_wait;
      end else if (owner == 2) begin
         e_grant = 2'b10; e_mreq = D_req; e_mwrite = D_write; e_maddr = D_addr;
         e_min = D_in; e_mtype = D_type; e_dout = M_out; e_dwait = M_wait;
      end
      chk("grant", 32'(grant), 32'(e_grant));
      chk("M_req", 32'(M_req), 32'(e_mreq));
      chk("M_write", 32'(M_write), 32'(e_mwrite));
      chk("M_addr", M_addr, e_maddr);
      chk("M_in", M_in, e_min);
      chk("M_type", 32'(M_type), 32'(e_mtype));
      chk("I_out", I_out, e_iout);
      chk("D_out", D_out, e_dout);
      chk("I_wait", 32'(I_wait), 32'(e_iwait));
      chk("D_wait", 32'(D_wait), 32'(e_dwait));
      chk("cnt_i", 32'(cnt_i_grants), 32'(m_cnt_i));
      chk("cnt_d", 32'(cnt_d_grants), 32'(m_cnt_d));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      I_req = 0; I_write = 0; I_addr = '0; I_in = '0; I_type = '0;
      D_req = 0; D_write = 0; D_addr = '0; D_in = '0; D_type = '0;
      M_wait = 1; M_out = '0;
   endtask

   task automatic do_reset();
      rst = 1;
      clear_inputs();
      cyc();
      cyc();
      rst = 0;
   endtask

   logic [1:0] rr [8];

   initial begin
      do_reset();

      // I-only read, beats on cycles 3,5,6,8
      I_req = 1; I_write = 0; I_addr = 32'h0001_0040; I_in = 32'h1111_1111; I_type = 3'd2;
      for (int k = 1; k <= 10; k++) begin
         cyc();
         M_wait = (k == 3 || k == 5 || k == 6 || k == 8) ? 1'b0 : 1'b1;
         M_out  = 32'hA000_0000 + 32'(k);
         if (k == 9) I_req = 0;
         #1;
         if (k == 1) begin
            chk("t1_grant", 32'(grant), 32'h1);
            chk("t1_addr", M_addr, 32'h0001_0040);
         end
         if (k == 8) chk("t1_iout", I_out, 32'hA000_0008);
         if (k == 9) begin
            chk("t1_idle", 32'(grant), 32'h0);
            chk("t1_cnt_i", 32'(cnt_i_grants), 32'h1);
         end
      end

      // Simultaneous requests after reset: D write first, then I read
      do_reset();
      I_req = 1; I_write = 0; I_addr = 32'h0001_0080;
      D_req = 1; D_write = 1; D_addr = 32'h0002_0004; D_in = 32'hDEAD_BEEF; D_type = 3'd1;
      M_wait = 0;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         M_out = 32'hB000_0000 + 32'(k);
         if (k == 2) D_req = 0;
         if (k == 7) I_req = 0;
         #1;
         if (k == 1) begin
            chk("t2_grant_d", 32'(grant), 32'h2);
            chk("t2_min", M_in, 32'hDEAD_BEEF);
            chk("t2_iwait", 32'(I_wait), 32'h1);
         end
         if (k == 2) chk("t2_idle1", 32'(grant), 32'h0);
         if (k == 3) chk("t2_grant_i", 32'(grant), 32'h1);
         if (k == 6) chk("t2_still_i", 32'(grant), 32'h1);
         if (k == 7) chk("t2_idle2", 32'(grant), 32'h0);
      end

      // Round-robin with both masters requesting writes continuously
      do_reset();
      rr = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
      I_req = 1; I_write = 1; I_addr = 32'h0000_0100;
      D_req = 1; D_write = 1; D_addr = 32'h0000_0200;
      M_wait = 0;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         if (k == 7) begin I_req = 0; D_req = 0; end
         #1;
         chk("t3_rr", 32'(grant), 32'(rr[k-1]));
      end

      // I read with req dropped after beat 2
      I_req = 1; I_write = 0; I_addr = 32'h0003_0000; D_req = 0; M_wait = 0;
      for (int k = 1; k <= 7; k++) begin
         cyc();
         M_wait = (k == 3) ? 1'b1 : 1'b0;
         if (k == 3) I_req = 0;
         #1;
         if (k >= 3 && k <= 5) begin
            chk("t4_hold", 32'(grant), 32'h1);
            chk("t4_mreq", 32'(M_req), 32'h0);
         end
         if (k == 6) chk("t4_idle", 32'(grant), 32'h0);
      end

      // Asynchronous reset during beat 2 of a D read
      I_req = 0; D_req = 1; D_write = 0; D_addr = 32'h0004_0000; M_wait = 0;
      cyc(); #1;
      chk("t5_grant", 32'(grant), 32'h2);
      cyc(); #2;
      rst = 1;
      #1;
      chk("t5_rst_grant", 32'(grant), 32'h0);
      chk("t5_rst_mreq", 32'(M_req), 32'h0);
      chk("t5_rst_cnt_i", 32'(cnt_i_grants), 32'h0);
      chk("t5_rst_cnt_d", 32'(cnt_d_grants), 32'h0);
      chk("t5_rst_dwait", 32'(D_wait), 32'h1);
      cyc(); cyc();
      rst = 0;
      I_req = 1; I_write = 0; D_req = 1; D_write = 1;
      cyc(); #1;
      chk("t5_tie_d", 32'(grant), 32'h2);
      I_req = 0; D_req = 0;
      cyc(); cyc(); cyc();

      // Counter wrap: one I write, then 2^CNT_W D writes
      do_reset();
      I_req = 1; I_write = 1; M_wait = 0;
      cyc();
      I_req = 0;
      cyc();
      D_req = 1; D_write = 1; D_addr = 32'h0005_0000;
      for (int n = 1; n <= 512; n++) begin
         cyc();
         if (n == 510) chk("t6_cnt_d_255", 32'(cnt_d_grants), 32'd255);
      end
      D_req = 0;
      #1;
      chk("t6_wrap", 32'(cnt_d_grants), 32'h0);
      chk("t6_cnt_i", 32'(cnt_i_grants), 32'h1);
      cyc(); cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
